// File: rtl/lane_mul_pkg.sv
// Shared sizing, lane slice helpers and LED bit positions for the lane multiply buffer.
package lane_mul_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_LANES      = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned BUS_WIDTH      = 2 * DEF_LANES * DEF_DATA_WIDTH;
    localparam int unsigned PROD_WIDTH     = 2 * DEF_DATA_WIDTH;

    localparam int unsigned LED_BUSY     = 9;
    localparam int unsigned LED_RD_ERR   = 8;
    localparam int unsigned LED_RD_STALE = 7;

    function automatic int unsigned a_lsb(input int unsigned lane, input int unsigned w);
        return 2 * lane * w;
    endfunction

    function automatic int unsigned b_lsb(input int unsigned lane, input int unsigned w);
        return (2 * lane + 1) * w;
    endfunction

    function automatic int unsigned prod_lsb(input int unsigned lane, input int unsigned w);
        return 2 * lane * w;
    endfunction

endpackage

// File: rtl/lane_mul_stage.sv
// Two-stage operand/product pipeline: S1 captures an accepted write, S2 holds one product per lane.
module lane_mul_stage
    import lane_mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit          SIGNED     = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            we,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [2*LANES*DATA_WIDTH-1:0]   data,
    output logic                            s1_valid,
    output logic [ADDR_WIDTH-1:0]           s1_addr,
    output logic                            s2_valid,
    output logic [ADDR_WIDTH-1:0]           s2_addr,
    output logic [2*LANES*DATA_WIDTH-1:0]   s2_prod
);

    localparam int unsigned W = DATA_WIDTH;
    localparam int unsigned P = 2 * DATA_WIDTH;
    localparam int unsigned B = 2 * LANES * DATA_WIDTH;

    logic [B-1:0] s1_data;
    logic [B-1:0] prod;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= we;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            s1_addr <= addr;
            s1_data <= data;
        end
        if (s1_valid) begin
            s2_addr <= s1_addr;
            s2_prod <= prod;
        end
    end

    // Operands are extended to the full product width first, so the low P bits
    // of a plain P x P multiply are correct for both signed and unsigned builds.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [P-1:0] a_ext;
        logic [P-1:0] b_ext;

        assign a     = s1_data[a_lsb(i, W) +: W];
        assign b     = s1_data[b_lsb(i, W) +: W];
        assign a_ext = SIGNED ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        assign b_ext = SIGNED ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        assign prod[prod_lsb(i, W) +: P] = a_ext * b_ext;
    end

endmodule

// File: rtl/lane_mul_ram.sv
// Lane-parallel multiply buffer: pipelined products written back into a result RAM
// read through the shared address port, with per-entry valid and hazard flags.
module lane_mul_ram
    import lane_mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit          SIGNED     = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            we,
    input  logic                            re,
    input  logic                            clear,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [2*LANES*DATA_WIDTH-1:0]   data,
    output logic [2*LANES*DATA_WIDTH-1:0]   q,
    output logic                            rd_valid,
    output logic                            rd_err,
    output logic                            rd_stale,
    output logic                            busy,
    output logic [15:0]                     done_count,
    output logic [9:0]                      leds
);

    localparam int unsigned B     = 2 * LANES * DATA_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [B-1:0]          mem [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic                  s1_valid;
    logic                  s2_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic [B-1:0]          s2_prod;
    logic                  rd_fire;
    logic                  hit_s1;
    logic                  hit_wb;
    logic                  entry_valid;
    logic [B-1:0]          rd_word;
    logic                  err_sticky;
    logic                  stale_sticky;

    lane_mul_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SIGNED     (SIGNED)
    ) u_stage (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (we),
        .addr     (addr),
        .data     (data),
        .s1_valid (s1_valid),
        .s1_addr  (s1_addr),
        .s2_valid (s2_valid),
        .s2_addr  (s2_addr),
        .s2_prod  (s2_prod)
    );

    // S2 always writes back on the next edge, so an S2 match is served by bypass
    // and only an S1 match is still in flight from the reader's point of view.
    assign rd_fire     = re & ~we;
    assign hit_s1      = s1_valid && (s1_addr == addr);
    assign hit_wb      = s2_valid && (s2_addr == addr);
    assign entry_valid = valid[addr] | hit_wb;
    assign busy        = s1_valid | s2_valid;

    always_comb begin
        rd_word = '0;
        if (entry_valid) begin
            rd_word = hit_wb ? s2_prod : mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (s2_valid) begin
            mem[s2_addr] <= s2_prod;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q            <= '0;
            rd_valid     <= 1'b0;
            rd_err       <= 1'b0;
            rd_stale     <= 1'b0;
            valid        <= '0;
            done_count   <= '0;
            err_sticky   <= 1'b0;
            stale_sticky <= 1'b0;
        end else begin
            rd_valid     <= rd_fire;
            rd_err       <= rd_fire & ~entry_valid;
            rd_stale     <= rd_fire & hit_s1;
            if (rd_fire) begin
                q <= rd_word;
            end
            err_sticky   <= (err_sticky & ~clear) | (rd_fire & ~entry_valid);
            stale_sticky <= (stale_sticky & ~clear) | (rd_fire & hit_s1);
            // Clear does not flush the pipe: a same-edge write-back still marks its entry.
            if (clear) begin
                valid <= '0;
            end
            if (s2_valid) begin
                valid[s2_addr] <= 1'b1;
            end
            done_count <= (clear ? 16'h0000 : done_count) + 16'(s2_valid);
        end
    end

    always_comb begin
        leds               = '0;
        leds[LED_BUSY]     = busy;
        leds[LED_RD_ERR]   = err_sticky;
        leds[LED_RD_STALE] = stale_sticky;
    end

endmodule

// File: tb/tb_lane_mul_ram.sv
// Directed bench for lane_mul_ram: a signed and an unsigned build share one stimulus stream.
module tb_lane_mul_ram;
    import lane_mul_pkg::*;

    typedef struct packed {
        logic [5:0]        addr;
        logic [3:0][15:0]  a;
        logic [3:0][15:0]  b;
        logic [127:0]      ps;
        logic [127:0]      pu;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         we;
    logic         re;
    logic         clear;
    logic [5:0]   addr;
    logic [127:0] data;

    logic [127:0] q;
    logic         rd_valid;
    logic         rd_err;
    logic         rd_stale;
    logic         busy;
    logic [15:0]  done_count;
    logic [9:0]   leds;

    logic [127:0] q_u;
    logic         rd_valid_u;
    logic         rd_err_u;
    logic         rd_stale_u;
    logic         busy_u;
    logic [15:0]  done_count_u;
    logic [9:0]   leds_u;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t tbl [5];

    always #5 clk = ~clk;

    lane_mul_ram #(
        .DATA_WIDTH (16),
        .LANES      (4),
        .ADDR_WIDTH (6),
        .SIGNED     (1'b1)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (we),
        .re         (re),
        .clear      (clear),
        .addr       (addr),
        .data       (data),
        .q          (q),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err),
        .rd_stale   (rd_stale),
        .busy       (busy),
        .done_count (done_count),
        .leds       (leds)
    );

    lane_mul_ram #(
        .DATA_WIDTH (16),
        .LANES      (4),
        .ADDR_WIDTH (6),
        .SIGNED     (1'b0)
    ) u_dut_u (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (we),
        .re         (re),
        .clear      (clear),
        .addr       (addr),
        .data       (data),
        .q          (q_u),
        .rd_valid   (rd_valid_u),
        .rd_err     (rd_err_u),
        .rd_stale   (rd_stale_u),
        .busy       (busy_u),
        .done_count (done_count_u),
        .leds       (leds_u)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [127:0] d);
        we   = 1'b1;
        re   = 1'b0;
        addr = a;
        data = d;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        re   = 1'b1;
        we   = 1'b0;
        addr = a;
        tick();
        re   = 1'b0;
    endtask

    function automatic logic [127:0] pack(input logic [3:0][15:0] a, input logic [3:0][15:0] b);
        logic [127:0] d;
        d = '0;
        for (int l = 0; l < 4; l++) begin
            d[32*l +: 16]      = a[l];
            d[32*l + 16 +: 16] = b[l];
        end
        return d;
    endfunction

    task automatic sweep_word(input int ad, output logic [127:0] d,
                              output logic [127:0] es, output logic [127:0] eu);
        int pa;
        int pb;
        int ub;
        d  = '0;
        es = '0;
        eu = '0;
        for (int l = 0; l < 4; l++) begin
            pa = ad + 100 * l;
            pb = -(ad + 1);
            ub = 65535 - ad;
            d[32*l +: 16]      = 16'(pa);
            d[32*l + 16 +: 16] = 16'(pb);
            es[32*l +: 32]     = 32'(pa * pb);
            eu[32*l +: 32]     = 32'(pa * ub);
        end
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] es;
        logic [127:0] eu;

        tbl[0] = '{addr: 6'd10,
                   a:  {16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h8000},
                   b:  {16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000},
                   ps: {32'hC0008000, 32'h3FFF0001, 32'h00000001, 32'h40000000},
                   pu: {32'h3FFF8000, 32'h3FFF0001, 32'hFFFE0001, 32'h40000000}};
        tbl[1] = '{addr: 6'd11,
                   a:  {16'hFFFF, 16'h1234, 16'h0002, 16'h0000},
                   b:  {16'h0001, 16'h0010, 16'hFFFF, 16'h1234},
                   ps: {32'hFFFFFFFF, 32'h00012340, 32'hFFFFFFFE, 32'h00000000},
                   pu: {32'h0000FFFF, 32'h00012340, 32'h0001FFFE, 32'h00000000}};
        tbl[2] = '{addr: 6'd12,
                   a:  {16'hFFFE, 16'h00FF, 16'h0100, 16'h8000},
                   b:  {16'hFFFE, 16'hFF00, 16'h0100, 16'h0001},
                   ps: {32'h00000004, 32'hFFFF0100, 32'h00010000, 32'hFFFF8000},
                   pu: {32'hFFFC0004, 32'h00FE0100, 32'h00010000, 32'h00008000}};
        tbl[3] = '{addr: 6'd63,
                   a:  {16'h8000, 16'h0100, 16'h00FF, 16'hFFFE},
                   b:  {16'h0001, 16'h0100, 16'hFF00, 16'hFFFE},
                   ps: {32'hFFFF8000, 32'h00010000, 32'hFFFF0100, 32'h00000004},
                   pu: {32'h00008000, 32'h00010000, 32'h00FE0100, 32'hFFFC0004}};
        tbl[4] = '{addr: 6'd0,
                   a:  {16'h8000, 16'hFFFF, 16'h7FFF, 16'h7FFF},
                   b:  {16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000},
                   ps: {32'h40000000, 32'h00000001, 32'h3FFF0001, 32'hC0008000},
                   pu: {32'h40000000, 32'hFFFE0001, 32'h3FFF0001, 32'h3FFF8000}};

        reset_n = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        clear   = 1'b0;
        addr    = '0;
        data    = '0;
        repeat (3) tick();
        check("reset_q", q, '0);
        check("reset_flags", {rd_valid, rd_err, rd_stale, busy}, 4'b0000);
        check("reset_done", done_count, 16'h0000);
        check("reset_leds", leds, 10'h000);
        reset_n = 1'b1;
        tick();

        // invalid entry read
        rd(6'd5);
        check("inv_flags", {rd_valid, rd_err, rd_stale}, 3'b110);
        check("inv_q", q, '0);
        check("inv_leds", leds, 10'h100);

        // basic write then read after two idle cycles
        wr(6'd3, {16'd9, 16'd7, 16'd9, 16'd7, 16'd9, 16'd7, 16'hFFFE, 16'd3});
        tick();
        tick();
        rd(6'd3);
        check("basic_q", q, {32'h3F, 32'h3F, 32'h3F, 32'hFFFFFFFA});
        check("basic_q_u", q_u, {32'h3F, 32'h3F, 32'h3F, 32'h0002FFFA});
        check("basic_flags", {rd_valid, rd_err, rd_stale}, 3'b100);
        check("basic_done", done_count, 16'd1);

        // stale read then bypass read on the write-back edge
        wr(6'd1, pack(tbl[2].a, tbl[2].b));
        tick();
        tick();
        wr(6'd1, pack(tbl[0].a, tbl[0].b));
        check("stale_busy", busy, 1'b1);
        rd(6'd1);
        check("stale_flags", {rd_valid, rd_err, rd_stale}, 3'b101);
        check("stale_q", q, tbl[2].ps);
        check("stale_q_u", q_u, tbl[2].pu);
        rd(6'd1);
        check("bypass_flags", {rd_valid, rd_err, rd_stale}, 3'b100);
        check("bypass_q", q, tbl[0].ps);
        check("bypass_leds", leds, 10'h180);

        // table: back-to-back writes, busy tail, then read-back
        for (int i = 0; i < 5; i++) begin
            wr(tbl[i].addr, pack(tbl[i].a, tbl[i].b));
        end
        check("tail_busy0", busy, 1'b1);
        tick();
        check("tail_busy1", busy, 1'b1);
        tick();
        check("tail_busy2", busy, 1'b0);
        check("tbl_done", done_count, 16'd8);
        for (int i = 0; i < 5; i++) begin
            rd(tbl[i].addr);
            check($sformatf("tbl%0d_q", i), q, tbl[i].ps);
            check($sformatf("tbl%0d_q_u", i), q_u, tbl[i].pu);
            check($sformatf("tbl%0d_err", i), {rd_valid, rd_err, rd_stale}, 3'b100);
        end

        // same address back to back: last write wins
        wr(6'd20, pack(tbl[0].a, tbl[0].b));
        wr(6'd20, pack(tbl[1].a, tbl[1].b));
        tick();
        tick();
        rd(6'd20);
        check("last_wins_q", q, tbl[1].ps);
        check("last_wins_done", done_count, 16'd10);

        // full-depth sweep after clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_done", done_count, 16'd0);
        check("clear_leds", leds, 10'h000);
        for (int i = 0; i < 64; i++) begin
            sweep_word(i, d, es, eu);
            wr(6'(i), d);
        end
        tick();
        tick();
        check("sweep_done", done_count, 16'd64);
        for (int i = 0; i < 64; i++) begin
            sweep_word(i, d, es, eu);
            rd(6'(i));
            check($sformatf("sweep%0d_q", i), q, es);
            check($sformatf("sweep%0d_q_u", i), q_u, eu);
        end

        // done_count wrap
        for (int i = 0; i < 65471; i++) begin
            wr(6'd0, '0);
        end
        tick();
        tick();
        check("wrap_ffff", done_count, 16'hFFFF);
        wr(6'd0, '0);
        tick();
        tick();
        check("wrap_zero", done_count, 16'h0000);
        check("wrap_zero_u", done_count_u, 16'h0000);

        // clear on the write-back edge keeps that entry valid
        wr(6'd40, pack(tbl[1].a, tbl[1].b));
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_wb_done", done_count, 16'd1);
        check("clr_wb_leds", leds, 10'h000);
        rd(6'd40);
        check("clr_wb_flags", {rd_valid, rd_err, rd_stale}, 3'b100);
        check("clr_wb_q", q, tbl[1].ps);
        rd(6'd3);
        check("clr_other_flags", {rd_valid, rd_err, rd_stale}, 3'b110);
        check("clr_other_q", q, '0);
        check("clr_other_leds", leds, 10'h100);

        // reset mid-pipeline discards the in-flight write
        wr(6'd50, pack(tbl[2].a, tbl[2].b));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_q", q, '0);
        check("mid_rst_leds", leds, 10'h000);
        tick();
        tick();
        check("mid_rst_done", done_count, 16'd0);
        rd(6'd50);
        check("mid_rst_flags", {rd_valid, rd_err, rd_stale}, 3'b110);
        check("mid_rst_q_u", {rd_valid_u, rd_err_u, q_u}, {2'b11, 128'h0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
